// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two 4*NIBBLES-bit operands one nibble per clock
// through a single 4-bit carry-lookahead slice. The inter-nibble carry is
// registered. A START/BUSY/DONE handshake launches an add and reports its result.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic                   CIN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [4*NIBBLES-1:0]   SUM,
    output logic                   COUT
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      op_a_q, op_a_d;
    logic [W-1:0]      op_b_q, op_b_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;

    // Nibble bit offset (idx * 4)
    logic [IdxW+1:0]   nib_base;
    logic [3:0]        cla_a, cla_b, cla_sum;
    logic [3:0]        cla_g, cla_p;
    logic [4:0]        cla_c;

    assign nib_base = {idx_q, 2'b00};
    assign cla_a    = op_a_q[nib_base +: 4];
    assign cla_b    = op_b_q[nib_base +: 4];

    // 4-bit carry-lookahead slice: all carries computed in parallel from g/p
    always_comb begin
        cla_g    = cla_a & cla_b;
        cla_p    = cla_a ^ cla_b;
        cla_c[0] = carry_q;
        cla_c[1] = cla_g[0] | (cla_p[0] & cla_c[0]);
        cla_c[2] = cla_g[1] | (cla_p[1] & cla_g[0]) | (cla_p[1] & cla_p[0] & cla_c[0]);
        cla_c[3] = cla_g[2] | (cla_p[2] & cla_g[1]) | (cla_p[2] & cla_p[1] & cla_g[0])
                 | (cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
        cla_c[4] = cla_g[3] | (cla_p[3] & cla_g[2]) | (cla_p[3] & cla_p[2] & cla_g[1])
                 | (cla_p[3] & cla_p[2] & cla_p[1] & cla_g[0])
                 | (cla_p[3] & cla_p[2] & cla_p[1] & cla_p[0] & cla_c[0]);
        cla_sum  = cla_p ^ cla_c[3:0];
    end

    // Next-state: operand capture, nibble sequencing and result collection
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    op_a_d  = A;
                    op_b_d  = B;
                    carry_d = CIN;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d[nib_base +: 4] = cla_sum;
                carry_d              = cla_c[4];
                if (idx_q == IdxLast) begin
                    cout_d  = cla_c[4];
                    state_d = StFin;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset clears result and aborts any add
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);
    assign SUM  = sum_q;
    assign COUT = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: three instances (NIBBLES = 1, 4, 8) share
// clock, reset and handshake inputs; directed scenarios target the 4-nibble
// instance, and the random sweep checks all three against plain arithmetic.
module tb_nibble_serial_adder;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in, b_in;
    logic        cin;

    logic        busy1, done1, cout1;
    logic [3:0]  sum1;
    logic        busy4, done4, cout4;
    logic [15:0] sum4;
    logic        busy8, done8, cout8;
    logic [31:0] sum8;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .CLK(clk), .RESET(reset), .START(start), .A(a_in[3:0]), .B(b_in[3:0]), .CIN(cin),
        .BUSY(busy1), .DONE(done1), .SUM(sum1), .COUT(cout1)
    );

    nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
        .CLK(clk), .RESET(reset), .START(start), .A(a_in[15:0]), .B(b_in[15:0]), .CIN(cin),
        .BUSY(busy4), .DONE(done4), .SUM(sum4), .COUT(cout4)
    );

    nibble_serial_adder #(.NIBBLES(8)) u_dut8 (
        .CLK(clk), .RESET(reset), .START(start), .A(a_in), .B(b_in), .CIN(cin),
        .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse START for one edge; returns at the first negedge after acceptance
    task automatic start_add(input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges (starting at 1) until done4 is seen, bounded at 20
    task automatic wait_done4(output int c);
        c = 1;
        while (done4 !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy4, done4, cout4, sum4} !== 19'd0) begin
            errors++;
            $display("FAIL reset_n4: busy=%b done=%b cout=%b sum=%h expected all zero",
                     busy4, done4, cout4, sum4);
        end
        checks++;
        if ({busy1, done1, busy8, done8, sum8, sum1} !== 40'd0) begin
            errors++;
            $display("FAIL reset_n1_n8: busy1=%b done1=%b busy8=%b done8=%b sum8=%h sum1=%h",
                     busy1, done1, busy8, done8, sum8, sum1);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        start_add(32'h1234, 32'h4321, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy cycle %0d: busy=%b done=%b expected busy=1 done=0",
                         i, busy4, done4);
            end
            @(negedge clk);
        end
        checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || sum4 !== 16'h5555 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b sum=%h cout=%b expected 1 0 5555 0",
                     done4, busy4, sum4, cout4);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || sum4 !== 16'h5555) begin
            errors++;
            $display("FAIL basic_hold: done=%b sum=%h expected done=0 sum=5555", done4, sum4);
        end
    endtask

    task automatic test_ripple();
        int c;
        start_add(32'hFFFF, 32'h0000, 1'b1);
        wait_done4(c);
        checks++;
        if (c !== 5 || sum4 !== 16'h0000 || cout4 !== 1'b1) begin
            errors++;
            $display("FAIL ripple: done_at=%0d sum=%h cout=%b expected 5 0000 1", c, sum4, cout4);
        end
    endtask

    task automatic test_max_then_small();
        int c;
        start_add(32'hFFFF, 32'hFFFF, 1'b1);
        wait_done4(c);
        checks++;
        if (c !== 5 || sum4 !== 16'hFFFF || cout4 !== 1'b1) begin
            errors++;
            $display("FAIL max_ops: done_at=%0d sum=%h cout=%b expected 5 ffff 1", c, sum4, cout4);
        end
        start_add(32'h0001, 32'h0001, 1'b0);
        checks++;
        if (sum4 !== 16'h0000 || cout4 !== 1'b0 || busy4 !== 1'b1) begin
            errors++;
            $display("FAIL clear_on_start: sum=%h cout=%b busy=%b expected 0000 0 1",
                     sum4, cout4, busy4);
        end
        wait_done4(c);
        checks++;
        if (c !== 5 || sum4 !== 16'h0002 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL small_ops: done_at=%0d sum=%h cout=%b expected 5 0002 0", c, sum4, cout4);
        end
    endtask

    task automatic test_start_busy();
        int n_done = 0;
        int first_c = 0;
        logic [15:0] s_at = '0;
        logic        co_at = 1'b0;
        start_add(32'h00F0, 32'h0010, 1'b0);
        start = 1'b1;
        a_in  = 32'hAAAA;
        b_in  = 32'h5555;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= 14; c++) begin
            if (done4 === 1'b1) begin
                n_done++;
                if (n_done == 1) begin
                    first_c = c;
                    s_at    = sum4;
                    co_at   = cout4;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (n_done !== 1 || first_c !== 5 || s_at !== 16'h0100 || co_at !== 1'b0) begin
            errors++;
            $display("FAIL start_during_busy: dones=%0d at=%0d sum=%h cout=%b expected 1 5 0100 0",
                     n_done, first_c, s_at, co_at);
        end
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        int c;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start_add(32'h1111, 32'h2222, 1'b0);
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b1 || sum4 !== 16'h0003) begin
            errors++;
            $display("FAIL partial_sum: busy=%b sum=%h expected 1 0003", busy4, sum4);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 16'h0000 || cout4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h cout=%b expected 0 0 0000 0",
                     busy4, done4, sum4, cout4);
        end
        for (int i = 0; i < 10; i++) begin
            if (done4 === 1'b1) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done !== 0) begin
            errors++;
            $display("FAIL reset_no_done: dones=%0d expected 0", n_done);
        end
        start_add(32'h8000, 32'h8000, 1'b0);
        wait_done4(c);
        checks++;
        if (c !== 5 || sum4 !== 16'h0000 || cout4 !== 1'b1) begin
            errors++;
            $display("FAIL after_reset: done_at=%0d sum=%h cout=%b expected 5 0000 1",
                     c, sum4, cout4);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        c_in;
        logic [4:0]  e1;
        logic [16:0] e4;
        logic [32:0] e8;
        int n1, n4, n8;
        // Let all instances return to idle
        repeat (12) @(negedge clk);
        for (int v = 0; v < 500; v++) begin
            a    = $urandom;
            b    = $urandom;
            c_in = 1'($urandom_range(1));
            e1   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(c_in);
            e4   = {1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(c_in);
            e8   = {1'b0, a} + {1'b0, b} + 33'(c_in);
            n1 = 0; n4 = 0; n8 = 0;
            start_add(a, b, c_in);
            for (int c = 1; c <= 10; c++) begin
                if (done1 === 1'b1) begin
                    n1++;
                    checks++;
                    if (c !== 2 || {cout1, sum1} !== e1) begin
                        errors++;
                        $display("FAIL rand_n1 v%0d: at=%0d got=%h expected at=2 val=%h",
                                 v, c, {cout1, sum1}, e1);
                    end
                end
                if (done4 === 1'b1) begin
                    n4++;
                    checks++;
                    if (c !== 5 || {cout4, sum4} !== e4) begin
                        errors++;
                        $display("FAIL rand_n4 v%0d: at=%0d got=%h expected at=5 val=%h",
                                 v, c, {cout4, sum4}, e4);
                    end
                end
                if (done8 === 1'b1) begin
                    n8++;
                    checks++;
                    if (c !== 9 || {cout8, sum8} !== e8) begin
                        errors++;
                        $display("FAIL rand_n8 v%0d: at=%0d got=%h expected at=9 val=%h",
                                 v, c, {cout8, sum8}, e8);
                    end
                end
                if (c < 10) @(negedge clk);
            end
            checks++;
            if (n1 !== 1 || n4 !== 1 || n8 !== 1) begin
                errors++;
                $display("FAIL rand_done_count v%0d: n1=%0d n4=%0d n8=%0d expected 1 each",
                         v, n1, n4, n8);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        test_reset();
        test_basic();
        test_ripple();
        test_max_then_small();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
